// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
//   Shared definitions for the 64-bit core front end.
//   - Architectural widths (XLEN, ILEN) and the fetch stride (INSTR_BYTES).
//   - Major opcodes shared between the fetch stage and the immediate generator.
//   - fetch_entry_t: one fetch-buffer slot {pc, instr, filled}.
//   - align_pc(): forces a target address onto a word boundary.
// -----------------------------------------------------------------------------
package cpu_pkg;

  localparam int XLEN        = 64;
  localparam int ILEN        = 32;
  localparam int INSTR_BYTES = 4;

  // Major opcodes (instr[6:0]) consumed by the immediate generator / decoder.
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
    logic            filled;
  } fetch_entry_t;

  // Instructions are word aligned; the low two bits of any target are dropped.
  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit_if
//   Bundles the two handshakes of the fetch stage:
//     imem_req_*  : fetch requests to instruction memory (valid/ready)
//     imem_rsp_*  : in-order responses from memory (valid only, no backpressure)
//     if_*        : instructions presented to decode (valid/ready)
//   Modports:
//     master : the fetch unit (drives requests and the decode-side outputs)
//     slave  : the environment (memory and decode)
// -----------------------------------------------------------------------------
interface instr_fetch_unit_if;
  import cpu_pkg::*;

  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_rsp_valid;
  logic [ILEN-1:0] imem_rsp_data;

  logic            if_valid;
  logic            if_ready;
  logic [ILEN-1:0] if_instruction;
  logic [XLEN-1:0] if_pc;

  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready,
    input  imem_rsp_valid, imem_rsp_data,
    output if_valid, if_instruction, if_pc,
    input  if_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready,
    output imem_rsp_valid, imem_rsp_data,
    input  if_valid, if_instruction, if_pc,
    output if_ready
  );

endinterface

// File: rtl/instr_fetch_unit_buf.sv
// -----------------------------------------------------------------------------
// fetch_buf
//   Circular buffer of DEPTH fetch entries with three independent pointers:
//     alloc_ptr : advanced when a fetch request is accepted (records its pc)
//     fill_ptr  : advanced when a response is written (records the instr)
//     rd_ptr    : advanced when decode pops the head entry
//   All pointers wrap naturally because DEPTH is a power of two.
//   Ports:
//     clk, rst_n      clock, asynchronous active-low reset
//     flush           discard every entry and zero all pointers/counts
//     alloc_en/pc     allocate the entry at alloc_ptr for this pc
//     fill_en/instr   write the instruction into the entry at fill_ptr
//     pop_en          retire the head entry (caller guarantees head.filled)
//     head            entry at rd_ptr
//     used            entries allocated and not yet popped
//     unfilled        entries allocated and not yet filled
// -----------------------------------------------------------------------------
module fetch_buf
  import cpu_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             alloc_en,
  input  logic [XLEN-1:0]  alloc_pc,
  input  logic             fill_en,
  input  logic [ILEN-1:0]  fill_instr,
  input  logic             pop_en,
  output fetch_entry_t     head,
  output logic [CNT_W-1:0] used,
  output logic [CNT_W-1:0] unfilled
);

  logic [XLEN-1:0]  pc_q    [DEPTH];
  logic [ILEN-1:0]  instr_q [DEPTH];
  logic [DEPTH-1:0] filled_q;

  logic [PTR_W-1:0] alloc_ptr;
  logic [PTR_W-1:0] fill_ptr;
  logic [PTR_W-1:0] rd_ptr;

  // NOTE: the payload arrays carry no reset; an entry is only observable
  // through its filled bit, and that bit is reset, so stale payload is harmless.
  always_ff @(posedge clk) begin
    if (alloc_en) pc_q[alloc_ptr]   <= alloc_pc;
    if (fill_en)  instr_q[fill_ptr] <= fill_instr;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of the others, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alloc_ptr <= '0;
      fill_ptr  <= '0;
      rd_ptr    <= '0;
      used      <= '0;
      unfilled  <= '0;
      filled_q  <= '0;
    end else if (flush) begin
      alloc_ptr <= '0;
      fill_ptr  <= '0;
      rd_ptr    <= '0;
      used      <= '0;
      unfilled  <= '0;
      filled_q  <= '0;
    end else begin
      // The three pointers never address the same slot in one cycle: alloc
      // targets a free slot, fill the oldest unfilled one, pop a filled one.
      if (alloc_en) begin
        filled_q[alloc_ptr] <= 1'b0;
        alloc_ptr           <= alloc_ptr + PTR_W'(1);
      end
      if (fill_en) begin
        filled_q[fill_ptr] <= 1'b1;
        fill_ptr           <= fill_ptr + PTR_W'(1);
      end
      if (pop_en) begin
        filled_q[rd_ptr] <= 1'b0;
        rd_ptr           <= rd_ptr + PTR_W'(1);
      end
      used     <= used + CNT_W'(alloc_en) - CNT_W'(pop_en);
      unfilled <= unfilled + CNT_W'(alloc_en) - CNT_W'(fill_en);
    end
  end

  assign head.pc     = pc_q[rd_ptr];
  assign head.instr  = instr_q[rd_ptr];
  assign head.filled = filled_q[rd_ptr];

endmodule

// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
//   Fetch stage of the 64-bit core. Owns the PC, issues in-order word fetches
//   to instruction memory, buffers up to DEPTH in-flight/returned instructions
//   and hands them to decode over a valid/ready handshake. A redirect flushes
//   the buffer and restarts fetch at the new target; responses still in flight
//   for the flushed requests are counted in `discard` and dropped on arrival.
//   Parameters:
//     DEPTH     buffer entries / max outstanding fetches (power of two, >= 2)
//     RESET_PC  first fetch address after reset (word aligned)
//   Ports:
//     clk, rst_n                  clock, asynchronous active-low reset
//     redirect_valid/redirect_pc  taken branch/jump; target low bits ignored
//     bus (master)                imem request/response and decode handshake
// -----------------------------------------------------------------------------
module instr_fetch_unit
  import cpu_pkg::*;
#(
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = 64'h0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                redirect_valid,
  input  logic [XLEN-1:0]     redirect_pc,
  instr_fetch_unit_if.master  bus
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [XLEN-1:0]  pc;
  logic [CNT_W-1:0] discard;
  logic             started;

  fetch_entry_t     head;
  logic [CNT_W-1:0] used;
  logic [CNT_W-1:0] unfilled;

  logic req_valid;
  logic accept;
  logic fill_en;
  logic pop_en;

  // Requests are held back until the first edge after reset release, and
  // whenever the buffer plus the still-to-be-dropped responses would overflow.
  // Keeping used + discard <= DEPTH bounds the outstanding fetches, so a
  // response always has an allocated slot (or a discard credit) waiting.
  assign req_valid = started && !redirect_valid &&
                     ((used + discard) < CNT_W'(DEPTH));
  assign accept    = req_valid && bus.imem_req_ready;
  assign fill_en   = bus.imem_rsp_valid && (discard == '0);
  assign pop_en    = head.filled && bus.if_ready;

  fetch_buf #(
    .DEPTH (DEPTH)
  ) u_buf (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (redirect_valid),
    .alloc_en   (accept),
    .alloc_pc   (pc),
    .fill_en    (fill_en),
    .fill_instr (bus.imem_rsp_data),
    .pop_en     (pop_en),
    .head       (head),
    .used       (used),
    .unfilled   (unfilled)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc      <= RESET_PC;
      discard <= '0;
      started <= 1'b0;
    end else begin
      started <= 1'b1;
      if (redirect_valid) begin
        pc <= align_pc(redirect_pc);
        // Every outstanding request (old discards plus unfilled entries) will
        // still be answered; the one answered this cycle is already accounted.
        discard <= discard + unfilled - CNT_W'(bus.imem_rsp_valid);
      end else begin
        if (accept) pc <= pc + XLEN'(INSTR_BYTES);
        if (bus.imem_rsp_valid && (discard != '0)) discard <= discard - CNT_W'(1);
      end
    end
  end

  assign bus.imem_req_valid = req_valid;
  assign bus.imem_req_addr  = pc;
  assign bus.if_valid       = head.filled;

  // Payload is masked while the head is empty so decode sees zeros, not
  // leftovers of an already popped or flushed entry.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path
    // leaves it unassigned and no latch is inferred.
    bus.if_instruction = '0;
    bus.if_pc          = '0;
    if (head.filled) begin
      bus.if_instruction = head.instr;
      bus.if_pc          = head.pc;
    end
  end

endmodule
